// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// bit-counter width helper.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADD  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Counter must index bits 0..width-1 but never collapse below one bit.
    function automatic int cnt_width(input int width);
        return ($clog2(width) > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit combinational full adder; the one arithmetic slice reused by
// serial_adder across all operand bits.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: {cout,sum} = a + b + cin over WIDTH cycles, LSB first.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic [WIDTH-1:0] s_nxt;
    logic             c_q;
    logic             fa_s;
    logic             fa_c;
    logic             last_bit;

    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (c_q),
        .sum  (fa_s),
        .cout (fa_c)
    );

    assign last_bit = (cnt == LAST);
    // New sum bit enters at the MSB so the result is aligned after WIDTH shifts.
    assign s_nxt = (s_sh >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ADD;
            ADD:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            a_sh <= '0;
            b_sh <= '0;
            s_sh <= '0;
            c_q  <= 1'b0;
            sum  <= '0;
            cout <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh <= a;
                        b_sh <= b;
                        c_q  <= cin;
                        cnt  <= '0;
                    end
                end
                ADD: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    s_sh <= s_nxt;
                    c_q  <= fa_c;
                    cnt  <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        sum  <= s_nxt;
                        cout <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
                        // Carry into the MSB is c_q while the MSB is processed.
                        ovf  <= c_q ^ fa_c;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8 and WIDTH=1 instances),
// checked against an arithmetic reference model.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start1, cin1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf8, ovf1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf8)
`endif
    );

    serial_adder #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf1)
`endif
    );

    // Reference: unsigned sum with carry, and signed overflow by range test.
    function automatic longint ref_sum(input longint x, input longint y, input longint ci);
        return x + y + ci;
    endfunction

    function automatic bit ref_ovf(input int w, input longint x, input longint y, input longint ci);
        longint sx, sy, tot, lim;
        lim = longint'(1) << (w - 1);
        sx  = (x >= lim) ? x - 2 * lim : x;
        sy  = (y >= lim) ? y - 2 * lim : y;
        tot = sx + sy + ci;
        return (tot > lim - 1) || (tot < -lim);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one op on the WIDTH=8 instance and reports what it observed.
    task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic ci,
                        output logic bsy, output int lat, output int nd,
                        output logic [7:0] s, output logic co, output logic ov);
        start8 = 1'b1; a8 = x; b8 = y; cin8 = ci;
        tick();
        bsy = busy8;
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        lat = -1; nd = 0; s = '0; co = 1'b0; ov = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (done8) begin
                nd++;
                if (lat < 0) begin
                    lat = i; s = sum8; co = cout8;
`ifdef SERIAL_ADDER_OVF_EN
                    ov = ovf8;
`endif
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
        start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        repeat (3) tick();
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy8); end
        checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done8); end
        checks++; if (sum8 !== 8'h00) begin errors++; $display("FAIL reset_sum: got %h expected 00", sum8); end
        checks++; if (cout8 !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b expected 0", cout8); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy1: got %b expected 0", busy1); end
`ifdef SERIAL_ADDER_OVF_EN
        checks++; if (ovf8 !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf8); end
`endif
        start8 = 1'b0; start1 = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_vectors();
        logic [7:0] va [3] = '{8'h5A, 8'hFF, 8'hFF};
        logic [7:0] vb [3] = '{8'h33, 8'h01, 8'hFF};
        logic       vc [3] = '{1'b0, 1'b0, 1'b1};
        logic bsy, co, ov;
        int lat, nd;
        logic [7:0] s;
        longint tot;
        for (int k = 0; k < 3; k++) begin
            run8(va[k], vb[k], vc[k], bsy, lat, nd, s, co, ov);
            tot = ref_sum(va[k], vb[k], vc[k]);
            checks++; if (bsy !== 1'b1) begin errors++; $display("FAIL vec%0d_busy: got %b expected 1", k, bsy); end
            checks++; if (lat != 8) begin errors++; $display("FAIL vec%0d_latency: got %0d expected 8", k, lat); end
            checks++; if (nd != 1) begin errors++; $display("FAIL vec%0d_done_count: got %0d expected 1", k, nd); end
            checks++; if (s !== tot[7:0]) begin errors++; $display("FAIL vec%0d_sum: got %h expected %h", k, s, tot[7:0]); end
            checks++; if (co !== tot[8]) begin errors++; $display("FAIL vec%0d_cout: got %b expected %b", k, co, tot[8]); end
            checks++; if (sum8 !== tot[7:0]) begin errors++; $display("FAIL vec%0d_sum_hold: got %h expected %h", k, sum8, tot[7:0]); end
`ifdef SERIAL_ADDER_OVF_EN
            checks++; if (ov !== ref_ovf(8, va[k], vb[k], vc[k])) begin errors++; $display("FAIL vec%0d_ovf: got %b expected %b", k, ov, ref_ovf(8, va[k], vb[k], vc[k])); end
`endif
        end
    endtask

    task automatic test_random();
        logic bsy, co, ov, ci;
        int lat, nd;
        logic [7:0] s, x, y;
        longint tot;
        for (int k = 0; k < 25; k++) begin
            x = 8'($urandom); y = 8'($urandom); ci = 1'($urandom);
            run8(x, y, ci, bsy, lat, nd, s, co, ov);
            tot = ref_sum(x, y, ci);
            checks++; if (lat != 8 || nd != 1) begin errors++; $display("FAIL rand%0d_timing: got lat %0d dones %0d expected lat 8 dones 1", k, lat, nd); end
            checks++; if ({co, s} !== tot[8:0]) begin errors++; $display("FAIL rand%0d_result: %h+%h+%b got %h expected %h", k, x, y, ci, {co, s}, tot[8:0]); end
`ifdef SERIAL_ADDER_OVF_EN
            checks++; if (ov !== ref_ovf(8, x, y, ci)) begin errors++; $display("FAIL rand%0d_ovf: got %b expected %b", k, ov, ref_ovf(8, x, y, ci)); end
`endif
        end
    endtask

    task automatic test_ignore_start();
        int nd = 0;
        longint tot = ref_sum(8'hC3, 8'h4E, 1);
        logic [7:0] s = '0;
        logic co = 1'b0;
        start8 = 1'b1; a8 = 8'hC3; b8 = 8'h4E; cin8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick();
        start8 = 1'b1; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        tick();
        start8 = 1'b0;
        for (int j = 4; j <= 18; j++) begin
            tick();
            checks++;
            if (busy8 !== (j <= 8)) begin errors++; $display("FAIL ignore_busy_c%0d: got %b expected %b", j, busy8, (j <= 8)); end
            if (done8) begin nd++; s = sum8; co = cout8; end
        end
        checks++; if (nd != 1) begin errors++; $display("FAIL ignore_done_count: got %0d expected 1", nd); end
        checks++; if ({co, s} !== tot[8:0]) begin errors++; $display("FAIL ignore_result: got %h expected %h", {co, s}, tot[8:0]); end
    endtask

    task automatic test_reset_mid();
        logic bsy, co, ov;
        int lat, nd;
        logic [7:0] s;
        start8 = 1'b1; a8 = 8'h7F; b8 = 8'h7F; cin8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy8); end
        checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", done8); end
        checks++; if (sum8 !== 8'h00 || cout8 !== 1'b0) begin errors++; $display("FAIL midrst_result: got %h expected 000", {cout8, sum8}); end
        nd = 0;
        for (int j = 0; j < 15; j++) begin
            tick();
            if (done8) nd++;
        end
        checks++; if (nd != 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses expected 0", nd); end
        run8(8'h10, 8'h20, 1'b0, bsy, lat, nd, s, co, ov);
        checks++; if (lat != 8 || nd != 1) begin errors++; $display("FAIL midrst_restart_timing: got lat %0d dones %0d expected lat 8 dones 1", lat, nd); end
        checks++; if ({co, s} !== 9'h030) begin errors++; $display("FAIL midrst_restart_sum: got %h expected 030", {co, s}); end
    endtask

    task automatic test_back_to_back();
        int times[$];
        start8 = 1'b1; a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i == 29) start8 = 1'b0;
            if (done8) begin
                times.push_back(i);
                checks++;
                if (sum8 !== 8'h02 || cout8 !== 1'b0) begin errors++; $display("FAIL b2b_sum_at%0d: got %h expected 002", i, {cout8, sum8}); end
            end
        end
        checks++; if (times.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", times.size()); end
        for (int k = 0; k < times.size(); k++) begin
            checks++;
            if (times[k] != k * 10 + 8) begin errors++; $display("FAIL b2b_time%0d: got %0d expected %0d", k, times[k], k * 10 + 8); end
        end
    endtask

    task automatic test_width1();
        int lat, nd;
        logic s, co, ov, bsy;
        longint tot;
        for (int k = 0; k < 8; k++) begin
            start1 = 1'b1; a1 = 1'(k >> 2); b1 = 1'(k >> 1); cin1 = 1'(k);
            tot = ref_sum(a1, b1, cin1);
            tick();
            bsy = busy1;
            start1 = 1'b0;
            lat = -1; nd = 0; s = 1'b0; co = 1'b0; ov = 1'b0;
            for (int i = 1; i <= 4; i++) begin
                tick();
                if (done1) begin
                    nd++;
                    if (lat < 0) begin
                        lat = i; s = sum1; co = cout1;
`ifdef SERIAL_ADDER_OVF_EN
                        ov = ovf1;
`endif
                    end
                end
            end
            checks++; if (bsy !== 1'b1 || lat != 1 || nd != 1) begin errors++; $display("FAIL w1_%0d_timing: got busy %b lat %0d dones %0d expected 1 1 1", k, bsy, lat, nd); end
            checks++; if ({co, s} !== tot[1:0]) begin errors++; $display("FAIL w1_%0d_result: got %b expected %b", k, {co, s}, tot[1:0]); end
`ifdef SERIAL_ADDER_OVF_EN
            checks++; if (ov !== ref_ovf(1, k >> 2 & 1, k >> 1 & 1, k & 1)) begin errors++; $display("FAIL w1_%0d_ovf: got %b expected %b", k, ov, ref_ovf(1, k >> 2 & 1, k >> 1 & 1, k & 1)); end
`else
            if (ov !== 1'b0) $display("w1_%0d unexpected ov state", k);
`endif
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_width1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
